prefetch_ctrl_nox: RTL and testbench

Instruction prefetch controller that sits directly upstream of the core's instruction FIFO.
- Issues sequential word fetch requests on a valid/ready address channel and accepts in-order responses.
- Writes non-stale responses into the FIFO.
- Throttles by credit (FIFO occupancy plus in-flight requests), so the FIFO never overflows.
- On a jump, clears the FIFO, redirects the PC and silently drops responses to stale in-flight requests.

---
 rtl/prefetch_ctrl_nox.sv | 164 ++++++++++++++++
 tb/tb_prefetch_ctrl_nox.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prefetch_ctrl_nox.sv
// Sequential instruction prefetcher feeding the core's instruction FIFO, throttled by credit.
// Optional macro PREFETCH_ERR_STOP_EN: a forwarded bus error halts fetching until the next jump.
module prefetch_ctrl_nox #(
   parameter int                    SLOTS      = 2,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_en_i,
   input  logic                       jump_i,
   input  logic [ADDR_WIDTH-1:0]      jump_addr_i,
   output logic                       req_valid_o,
   input  logic                       req_ready_i,
   output logic [ADDR_WIDTH-1:0]      req_addr_o,
   input  logic                       rsp_valid_i,
   input  logic [DATA_WIDTH-1:0]      rsp_data_i,
   input  logic                       rsp_error_i,
   output logic                       rsp_ready_o,
   output logic                       fifo_write_o,
   output logic [DATA_WIDTH:0]        fifo_data_o,
   output logic                       fifo_clear_o,
   input  logic [$clog2(SLOTS):0]     fifo_ocup_i
);

   localparam int CW = $clog2(SLOTS) + 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t                state_ff;
   logic                  req_valid_ff;
   logic [ADDR_WIDTH-1:0] req_addr_ff;
   logic                  rsp_ready_ff;
   logic [ADDR_WIDTH-1:0] pc_ff;
   logic [CW-1:0]         ot_ff;
   logic [CW-1:0]         discard_ff;
   logic                  stale_ff;

   logic                  live;
   logic                  jump_eff;
   logic                  req_fire;
   logic                  rsp_fire;
   logic                  drop;
   logic                  hold;
   logic                  fetch_ok;
   logic                  credit_ok;
   logic                  credit_after;
   logic [CW:0]           credit_sum;
   logic [CW-1:0]         ot_next;
   logic [CW-1:0]         disc_after_rsp;
   logic [CW-1:0]         discard_next;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  stale_next;

   // Nothing is honoured until the cycle after reset release; rsp_ready_ff marks that point.
   assign live     = rsp_ready_ff && !rst;
   assign jump_eff = jump_i && live;
   assign req_fire = req_valid_ff && req_ready_i && live;
   assign rsp_fire = rsp_valid_i && live;
   assign drop     = (discard_ff != '0) || jump_i;
   assign hold     = req_valid_ff && !req_fire;

   assign req_valid_o  = req_valid_ff;
   assign req_addr_o   = req_addr_ff;
   assign rsp_ready_o  = rsp_ready_ff;
   assign fifo_write_o = rsp_fire && !drop;
   assign fifo_data_o  = {rsp_error_i, rsp_data_i};
   assign fifo_clear_o = jump_eff;

   // One extra bit so ot + occupancy + 1 can never wrap.
   assign credit_sum   = {1'b0, ot_ff} + {1'b0, fifo_ocup_i};
   assign credit_ok    = credit_sum < (CW+1)'(SLOTS);
   assign credit_after = (credit_sum + (CW+1)'(1)) < (CW+1)'(SLOTS);

   assign ot_next = ot_ff + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, rsp_fire};

   // Response is retired before an accepted stale request is counted.
   assign disc_after_rsp = (rsp_fire && discard_ff != '0) ? discard_ff - 1'b1 : discard_ff;

   always_comb begin
      discard_next = disc_after_rsp;
      if (jump_eff)
         discard_next = ot_next;
      else if (req_fire && stale_ff)
         discard_next = disc_after_rsp + 1'b1;
   end

   always_comb begin
      pc_next = pc_ff;
      if (jump_eff)
         pc_next = jump_addr_i & ~ADDR_WIDTH'(3);
      else if (req_fire && !stale_ff)
         pc_next = pc_ff + ADDR_WIDTH'(4);
   end

   always_comb begin
      stale_next = stale_ff;
      if (jump_eff)
         stale_next = req_valid_ff && !req_ready_i;
      else if (req_fire)
         stale_next = 1'b0;
   end

`ifdef PREFETCH_ERR_STOP_EN
   logic err_stop_ff;
   logic err_set;

   assign err_set  = fifo_write_o && rsp_error_i;
   assign fetch_ok = fetch_en_i && !err_stop_ff && !err_set;

   always_ff @(posedge clk) begin
      if (rst)
         err_stop_ff <= 1'b0;
      else if (jump_eff)
         err_stop_ff <= 1'b0;
      else if (err_set)
         err_stop_ff <= 1'b1;
   end
`else
   assign fetch_ok = fetch_en_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_ff     <= IDLE;
         req_valid_ff <= 1'b0;
         req_addr_ff  <= RESET_PC;
         rsp_ready_ff <= 1'b0;
         pc_ff        <= RESET_PC;
         ot_ff        <= '0;
         discard_ff   <= '0;
         stale_ff     <= 1'b0;
      end else begin
         rsp_ready_ff <= 1'b1;
         pc_ff        <= pc_next;
         ot_ff        <= ot_next;
         discard_ff   <= discard_next;
         stale_ff     <= stale_next;
         // A presented request keeps its address until accepted, even across a jump.
         if (!hold)
            req_addr_ff <= pc_next;
         case (state_ff)
            IDLE: begin
               if (fetch_ok && credit_ok && !jump_i) begin
                  state_ff     <= REQ;
                  req_valid_ff <= 1'b1;
               end
            end
            REQ: begin
               if (req_fire && !(fetch_ok && credit_after)) begin
                  state_ff     <= IDLE;
                  req_valid_ff <= 1'b0;
               end
            end
            default: begin
               state_ff     <= IDLE;
               req_valid_ff <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prefetch_ctrl_nox.sv
// Directed bench for prefetch_ctrl_nox: burst, hold, jumps, stale request, error and mid-burst reset.
module tb_prefetch_ctrl_nox;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        jump;
   logic [31:0] jump_addr;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_error;
   logic        rsp_ready;
   logic        fifo_write;
   logic [32:0] fifo_data;
   logic        fifo_clear;
   logic [1:0]  ocup;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prefetch_ctrl_nox #(
      .SLOTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h100)
   ) dut (
      .clk(clk), .rst(rst), .fetch_en_i(fetch_en), .jump_i(jump), .jump_addr_i(jump_addr),
      .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
      .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_error_i(rsp_error),
      .rsp_ready_o(rsp_ready), .fifo_write_o(fifo_write), .fifo_data_o(fifo_data),
      .fifo_clear_o(fifo_clear), .fifo_ocup_i(ocup)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
         else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
      $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         assert (dut.discard_ff <= dut.ot_ff && dut.ot_ff <= 2)
            else begin
               miscompares++;
               $error("FAIL counters: discard=%0d ot=%0d required discard<=ot<=2",
                      dut.discard_ff, dut.ot_ff);
            end
      end
   end

   logic exp_after_err;

   initial begin
`ifdef PREFETCH_ERR_STOP_EN
      exp_after_err = 1'b0;
`else
      exp_after_err = 1'b1;
`endif
      rst = 1'b1; fetch_en = 1'b1; jump = 1'b0; jump_addr = '0; req_ready = 1'b1;
      rsp_valid = 1'b0; rsp_data = '0; rsp_error = 1'b0; ocup = '0;
      repeat (2) @(posedge clk);
      #1;
      jump = 1'b1; rsp_valid = 1'b1;
      #1;
      chk("rst_valid", req_valid, 0);
      chk("rst_rsp_ready", rsp_ready, 0);
      chk("rst_write", fifo_write, 0);
      chk("rst_clear", fifo_clear, 0);
      chk("rst_addr", req_addr, 64'h100);
      jump = 1'b0; rsp_valid = 1'b0;

      // Burst from RESET_PC, FIFO never drained
      nxt(); rst = 1'b0; #1;
      chk("rel_valid", req_valid, 0);
      chk("rel_rsp_ready", rsp_ready, 0);
      nxt(); #1;
      chk("b1_valid", req_valid, 1);
      chk("b1_addr", req_addr, 64'h100);
      chk("b1_rsp_ready", rsp_ready, 1);
      nxt(); rsp_valid = 1'b1; rsp_data = 32'h1111_0000; #1;
      chk("b2_addr", req_addr, 64'h104);
      chk("b2_write", fifo_write, 1);
      chk("b2_data", fifo_data, {1'b0, 32'h1111_0000});
      nxt(); ocup = 2'd1; rsp_data = 32'h2222_0004; #1;
      chk("b3_valid", req_valid, 0);
      chk("b3_write", fifo_write, 1);
      nxt(); ocup = 2'd2; rsp_valid = 1'b0; #1;
      chk("full_valid0", req_valid, 0);
      chk("full_write", fifo_write, 0);
      nxt(); #1;
      chk("full_valid1", req_valid, 0);

      // Held request
      nxt(); ocup = 2'd0; req_ready = 1'b0; #1;
      chk("hold_idle", req_valid, 0);
      for (int i = 0; i < 5; i++) begin
         nxt(); #1;
         chk("hold_valid", req_valid, 1);
         chk("hold_addr", req_addr, 64'h108);
      end
      nxt(); req_ready = 1'b1; #1;
      chk("hold_acc_addr", req_addr, 64'h108);
      nxt(); #1;
      chk("hold_next_addr", req_addr, 64'h10c);

      // Jump with two outstanding
      nxt(); jump = 1'b1; jump_addr = 32'h203; #1;
      chk("j1_clear", fifo_clear, 1);
      chk("j1_valid", req_valid, 0);
      nxt(); jump = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h3333_0000; #1;
      chk("j1_drop0", fifo_write, 0);
      chk("j1_noclear", fifo_clear, 0);
      nxt(); #1;
      chk("j1_drop1", fifo_write, 0);

      // Jump while request held
      nxt(); rsp_valid = 1'b0; req_ready = 1'b0; jump = 1'b1; jump_addr = 32'h300; #1;
      chk("j1_target_valid", req_valid, 1);
      chk("j1_target_addr", req_addr, 64'h200);
      chk("j2_clear", fifo_clear, 1);
      nxt(); jump = 1'b0; #1;
      chk("j2_held_addr", req_addr, 64'h200);
      nxt(); req_ready = 1'b1; #1;
      chk("j2_acc_addr", req_addr, 64'h200);
      nxt(); req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h4444_0000; #1;
      chk("j2_next_addr", req_addr, 64'h300);
      chk("j2_stale_drop", fifo_write, 0);
      nxt(); rsp_valid = 1'b0; req_ready = 1'b1; #1;
      chk("j2_acc300", req_addr, 64'h300);

      // Error response
      nxt(); req_ready = 1'b0; rsp_valid = 1'b1; rsp_error = 1'b1; rsp_data = 32'hDEAD_BEEF; #1;
      chk("err_addr", req_addr, 64'h304);
      chk("err_write", fifo_write, 1);
      chk("err_data", fifo_data, 64'h1_DEAD_BEEF);
      nxt(); rsp_valid = 1'b0; rsp_error = 1'b0; req_ready = 1'b1; #1;
      chk("err_pending_valid", req_valid, 1);
      chk("err_pending_addr", req_addr, 64'h304);
      nxt(); #1;
      chk("err_after_valid", req_valid, exp_after_err);

      // Mid-burst reset
      nxt(); rst = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h5555_0000; #1;
      chk("mrst_write", fifo_write, 0);
      chk("mrst_clear", fifo_clear, 0);
      nxt(); rst = 1'b0; rsp_valid = 1'b0; #1;
      chk("mrst_valid", req_valid, 0);
      chk("mrst_addr", req_addr, 64'h100);
      chk("mrst_rsp_ready", rsp_ready, 0);
      nxt(); #1;
      chk("mrst_first_valid", req_valid, 1);
      chk("mrst_first_addr", req_addr, 64'h100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
